rx_video_unpack: RTL
====================

RX_VIDEO_UNPACK -- requirements
Module: rx_video_unpack

Interface
REQ-001 Parameter H_PIX, default 640, pixels per line.
REQ-002 Parameter V_LINES, default 480, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output buffer entries (power of 2).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 RxData  input  12  received pixel from CC1200SPI_Top: [11:8] R, [7:4] G, [3:0] B.
REQ-007 RxValid  input  1  RxData valid this cycle, one pixel per pulse.
REQ-008 FrameSync  input  1  one-cycle pulse marking the start of a received frame.
REQ-009 m_axis_video_tdata  output  24  RGB888 pixel.
REQ-010 m_axis_video_tvalid  output  1  AXI-Stream valid.
REQ-011 m_axis_video_tready  input  1  AXI-Stream ready.
REQ-012 m_axis_video_tuser  output  1  start of frame, first pixel only.
REQ-013 m_axis_video_tlast  output  1  end of line, pixel H_PIX-1.
REQ-014 ClrErr  input  1  one-cycle pulse that clears the sticky error bits.
REQ-015 ErrStat  output  2  sticky flags: [0] overflow, [1] short frame.
REQ-016 FrameCnt  output  16  number of FrameSync pulses received, wraps.

Function
REQ-017 The FSM SHALL have two states: IDLE (reset state; RxValid ignored) and ACTIVE; IDLE->ACTIVE on FrameSync; ACTIVE has no exit except reset.
REQ-018 On FrameSync, column and row counters SHALL be cleared to 0 and sof_pend SHALL be set to 1.
REQ-019 FrameSync and RxValid in the same cycle SHALL make that pixel column 0, row 0, with tuser set.
REQ-020 In ACTIVE, each RxValid SHALL push {tdata, sof=sof_pend, eol=(col==H_PIX-1)} and clear sof_pend.
REQ-021 tdata SHALL be {R,R,G,G,B,B}: each nibble replicated to 8 bits.
REQ-022 col SHALL wrap H_PIX-1->0 and increment row; row SHALL wrap V_LINES-1->0.
REQ-023 Counters SHALL advance on every accepted-or-dropped RxValid in ACTIVE, so line geometry survives drops.
REQ-024 FIFO SHALL be full at count==FIFO_DEPTH. A push when full with no pop SHALL be dropped and SHALL set ErrStat[0]. A push when full with a simultaneous pop SHALL be accepted.
REQ-025 m_axis_video_tvalid SHALL equal FIFO not empty. A pop SHALL occur on tvalid&tready. tdata/tuser/tlast SHALL be stable while tvalid&~tready.
REQ-026 Latency SHALL be one cycle: a pixel pushed into an empty FIFO appears with tvalid high on the next clk edge.
REQ-027 If FrameSync arrives in ACTIVE with (col,row) != (0,0), ErrStat[1] SHALL be set. Buffered pixels are not flushed.
REQ-028 FrameCnt SHALL increment on every FrameSync, including the first one from IDLE.
REQ-029 ClrErr SHALL clear ErrStat. If an error condition occurs in the same cycle as ClrErr, the bit SHALL be set (set wins).

Reset
REQ-030 While rstn=0 at a clk edge, the block SHALL enter IDLE and clear: col, row, sof_pend, FIFO pointers/count, ErrStat, FrameCnt.
REQ-031 After reset, tvalid, tuser, tlast and tdata SHALL all be 0.
REQ-032 A reset mid-frame SHALL discard buffered pixels. No output pixel SHALL follow until the next FrameSync-started frame.

Structure
REQ-033 The shared package rx_video_pkg SHALL hold H_PIX/V_LINES/FIFO_DEPTH defaults, the FSM state enum (IDLE, ACTIVE), and the 26-bit FIFO entry typedef {sof, eol, rgb[23:0]}.
REQ-034 The FIFO SHALL be a sub-module rx_pix_fifo: synchronous, first-word fall-through, with count output.

Verification
REQ-035 Reset, then FrameSync, then 640 RxValid of 12'hF0A with tready=1 -> 640 beats of tdata 24'hFF00AA; tuser on beat 0 only; tlast on beat 639 only; ErrStat=0.
REQ-036 RxValid before any FrameSync -> no tvalid; FrameCnt=0.
REQ-037 FrameSync+RxValid same cycle, data 12'h123 -> first beat tdata 24'h112233 with tuser=1; FrameCnt=1.
REQ-038 tready=0, 20 pixels pushed with FIFO_DEPTH=16 -> 16 pixels retained, ErrStat=2'b01. Then tready=1 -> exactly 16 beats out. Then ClrErr -> ErrStat=0.
REQ-039 FrameSync after 100 pixels -> ErrStat[1]=1. The next pixel carries tuser=1, and tlast lands on its 640th pixel.
REQ-040 rstn=0 for one cycle with 5 pixels buffered -> tvalid=0 on the next cycle. Later pixels are ignored until FrameSync.

Source files
------------

// File: rtl/rx_video_pkg.sv
// Shared types and defaults for the received-video unpacker: frame geometry,
// FSM states and the buffered pixel entry.
package rx_video_pkg;

  localparam int H_PIX_DEF      = 640;
  localparam int V_LINES_DEF    = 480;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] rgb;
  } pix_entry_t;

  // RGB444 -> RGB888 by replicating each nibble, so full scale stays full scale
  function automatic logic [23:0] expandRgb(input logic [11:0] d);
    return {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]};
  endfunction

endpackage

// File: rtl/rx_pix_fifo.sv
// First-word fall-through pixel buffer with occupancy count. The head entry is
// visible on o_data whenever the buffer is non-empty and reads as zero otherwise.
module rx_pix_fifo
  import rx_video_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  pix_entry_t               i_data,
  input  logic                     i_pop,
  output pix_entry_t               o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  pix_entry_t        r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot being written, so full+pop still accepts
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_video_unpack.sv
// Converts the RGB444 pixel stream from the radio receiver into an AXI4-Stream
// video stream with start-of-frame/end-of-line markers and sticky error flags.
module rx_video_unpack
  import rx_video_pkg::*;
#(
  parameter int H_PIX      = H_PIX_DEF,
  parameter int V_LINES    = V_LINES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] RxData,
  input  logic        RxValid,
  input  logic        FrameSync,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  input  logic        ClrErr,
  output logic [1:0]  ErrStat,
  output logic [15:0] FrameCnt
);

  localparam int COL_W = $clog2(H_PIX);
  localparam int ROW_W = $clog2(V_LINES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_sofPend;
  logic [1:0]        r_errStat;
  logic [15:0]       r_frameCnt;

  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_drop;
  logic              w_shortFrame;
  logic              w_eol;
  logic [CNT_W-1:0]  w_count;
  pix_entry_t        w_entry;
  pix_entry_t        w_head;

  // A FrameSync coinciding with a pixel makes that pixel (0,0) of the new frame
  assign w_col   = FrameSync ? '0 : r_col;
  assign w_row   = FrameSync ? '0 : r_row;
  assign w_push  = RxValid & ((r_state == ACTIVE) | FrameSync);
  assign w_eol   = (w_col == COL_W'(H_PIX - 1));
  assign w_entry = '{sof: (FrameSync | r_sofPend), eol: w_eol, rgb: expandRgb(RxData)};

  assign w_pop        = ~w_empty & m_axis_video_tready;
  assign w_drop       = w_push & (w_count == CNT_W'(FIFO_DEPTH)) & ~w_pop;
  assign w_shortFrame = FrameSync & (r_state == ACTIVE) & ((r_col != '0) | (r_row != '0));

  rx_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (m_axis_video_tready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_axis_video_tvalid = ~w_empty;
  assign m_axis_video_tdata  = w_head.rgb;
  assign m_axis_video_tuser  = w_head.sof;
  assign m_axis_video_tlast  = w_head.eol;
  assign ErrStat             = r_errStat;
  assign FrameCnt            = r_frameCnt;

  // Counters advance on dropped pixels too, so line geometry survives overflow
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_sofPend  <= 1'b0;
      r_errStat  <= 2'b00;
      r_frameCnt <= 16'd0;
    end else begin
      if (FrameSync) begin
        r_state    <= ACTIVE;
        r_frameCnt <= r_frameCnt + 16'd1;
      end
      if (w_push) begin
        r_sofPend <= 1'b0;
        if (w_eol) begin
          r_col <= '0;
          r_row <= (w_row == ROW_W'(V_LINES - 1)) ? '0 : w_row + ROW_W'(1);
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
      end else if (FrameSync) begin
        r_col     <= '0;
        r_row     <= '0;
        r_sofPend <= 1'b1;
      end
      r_errStat <= (ClrErr ? 2'b00 : r_errStat) | {w_shortFrame, w_drop};
    end
  end

endmodule
